cpu_div_seq: RTL and testbench

CPU_DIV_SEQ -- requirements
Module: cpu_div_seq

---
 rtl/cpu_div_if.sv | 25 ++
 rtl/cpu_div_seq.sv | 128 ++++++++++++
 tb/tb_cpu_div_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_div_if.sv
// Handshake and result bus between the CPU pipeline and the sequential divider.
interface cpu_div_if;
  logic        cpu_stall;
  logic        flush;
  logic        start;
  logic        op_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dbz;

  modport master (
    output cpu_stall, flush, start, op_signed, a, b,
    input  busy, done, stall, quo, rem, dbz
  );

  modport slave (
    input  cpu_stall, flush, start, op_signed, a, b,
    output busy, done, stall, quo, rem, dbz
  );
endinterface

// File: rtl/cpu_div_seq.sv
// Sequential 32-bit restoring divider, signed/unsigned, one quotient bit per
// unstalled cycle. Operates on magnitudes and fixes signs when the result is
// written, so the iteration itself is purely unsigned.
module cpu_div_seq (
  input  logic       clk,
  input  logic       rst,
  cpu_div_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [32:0] prem_q;     // partial remainder
  logic [31:0] dvd_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dvs_q;      // divisor magnitude
  logic        sgn_q;
  logic        asgn_q;
  logic        bsgn_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;

  logic        accept;
  logic [33:0] trial;
  logic        ge;
  logic [32:0] prem_d;
  logic [31:0] dvd_d;
  logic        qneg;
  logic        rneg;
  logic [31:0] quo_d;
  logic [31:0] rem_d;
  logic [31:0] amag;
  logic [31:0] bmag;

  // Accept decode, one restoring step, sign-corrected result and operand magnitudes.
  always_comb begin
    accept = (state_q == S_IDLE || state_q == S_DONE) && bus.start &&
             !bus.flush && !bus.cpu_stall;
    trial  = {prem_q, dvd_q[31]};
    ge     = trial >= {2'b00, dvs_q};
    prem_d = ge ? 33'(trial - {2'b00, dvs_q}) : trial[32:0];
    dvd_d  = {dvd_q[30:0], ge};
    qneg   = sgn_q & (asgn_q ^ bsgn_q);
    rneg   = sgn_q & asgn_q;
    quo_d  = qneg ? -dvd_d : dvd_d;
    rem_d  = rneg ? -prem_d[31:0] : prem_d[31:0];
    amag   = (bus.op_signed && bus.a[31]) ? -bus.a : bus.a;
    bmag   = (bus.op_signed && bus.b[31]) ? -bus.b : bus.b;
  end

  // Main FSM: reset beats cpu_stall beats flush beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      asgn_q  <= 1'b0;
      bsgn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else if (!bus.cpu_stall) begin
      case (state_q)
        S_CALC: begin
          if (bus.flush) begin
            // Abort: results keep whatever the last completed divide left.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            prem_q <= prem_d;
            dvd_q  <= dvd_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quo_q   <= quo_d;
              rem_q   <= rem_d;
              dbz_q   <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike; DONE only differs by its done pulse.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (accept) begin
            sgn_q  <= bus.op_signed;
            asgn_q <= bus.a[31];
            bsgn_q <= bus.b[31];
            dvd_q  <= amag;
            dvs_q  <= bmag;
            prem_q <= '0;
            cnt_q  <= '0;
            if (bus.b == 32'd0) begin
              // Divide by zero skips the iteration entirely.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              quo_q   <= 32'hFFFF_FFFF;
              rem_q   <= bus.a;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.stall = !rst && (accept || state_q == S_CALC);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dbz   = dbz_q;
  assign bus.quo   = quo_q;
  assign bus.rem   = rem_q;

endmodule

// File: tb/tb_cpu_div_seq.sv
// Bench for cpu_div_seq: directed table, multi-cycle corner sequences and
// random operands checked against an arithmetic reference.
module tb_cpu_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_div_if dif ();
  cpu_div_seq dut (.clk(clk), .rst(rst), .bus(dif));

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_q, last_r;
  logic        last_z;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, 64-bit for signed so -2^31/-1 does not trap.
  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.start = 1'b1; dif.op_signed = sgn; dif.a = a; dif.b = b;
  endtask

  // One full operation from accept to the done cycle, with latency and result checks.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    lat = -1;
    tick();
    drive_op(v.sgn, v.a, v.b);
    @(negedge clk);
    chk({nm, ".stall_acc"}, 32'(dif.stall), 32'd1);
    for (int c = 1; c <= 60; c++) begin
      tick();
      dif.start = 1'b0;
      @(negedge clk);
      if (dif.done) begin lat = c; break; end
      if (c == 1) chk({nm, ".busy1"}, 32'(dif.busy), 32'd1);
    end
    chk({nm, ".lat"}, 32'(lat), 32'(v.lat));
    chk({nm, ".quo"}, dif.quo, v.q);
    chk({nm, ".rem"}, dif.rem, v.r);
    chk({nm, ".dbz"}, 32'(dif.dbz), 32'(v.z));
    chk({nm, ".stall_done"}, 32'(dif.stall), 32'd0);
    chk({nm, ".busy_done"}, 32'(dif.busy), 32'd0);
    last_q = v.q; last_r = v.r; last_z = v.z;
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   lat;
  int   seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
    tbl[3] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
    tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    tbl[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33};
    tbl[7] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1};

    // Reset: start held during reset must not be taken and stall stays low.
    rst = 1'b1;
    dif.cpu_stall = 1'b0; dif.flush = 1'b0;
    drive_op(1'b0, 32'd5, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    chk("rst.stall", 32'(dif.stall), 32'd0);
    chk("rst.done", 32'(dif.done), 32'd0);
    tick();
    rst = 1'b0; dif.start = 1'b0;
    @(negedge clk);
    chk("rst.busy", 32'(dif.busy), 32'd0);
    chk("rst.quo", dif.quo, 32'd0);
    chk("rst.rem", dif.rem, 32'd0);
    chk("rst.dbz", 32'(dif.dbz), 32'd0);
    chk("rst.stall_idle", 32'(dif.stall), 32'd0);

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    // Flush at CALC cycle 10: back to IDLE, no done, results untouched.
    tick();
    drive_op(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      tick();
      dif.start = 1'b0;
      if (c == 10) dif.flush = 1'b1;
    end
    @(negedge clk);
    chk("flush.busy10", 32'(dif.busy), 32'd1);
    tick();
    dif.flush = 1'b0;
    @(negedge clk);
    chk("flush.busy11", 32'(dif.busy), 32'd0);
    chk("flush.stall11", 32'(dif.stall), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.done) seen++;
    end
    chk("flush.nodone", 32'(seen), 32'd0);
    chk("flush.quo", dif.quo, last_q);
    chk("flush.rem", dif.rem, last_r);
    chk("flush.dbz", 32'(dif.dbz), 32'(last_z));

    // start together with flush in IDLE is ignored.
    tick();
    drive_op(1'b0, 32'd9, 32'd3);
    dif.flush = 1'b1;
    @(negedge clk);
    chk("sf.stall", 32'(dif.stall), 32'd0);
    tick();
    dif.start = 1'b0; dif.flush = 1'b0;
    @(negedge clk);
    chk("sf.busy", 32'(dif.busy), 32'd0);
    chk("sf.done", 32'(dif.done), 32'd0);

    // cpu_stall for cycles 10..14 pushes done to 38; then done held under stall.
    rv.sgn = 1'b0; rv.a = 32'h1234_5678; rv.b = 32'd1000;
    model(rv.sgn, rv.a, rv.b, rv.q, rv.r, rv.z);
    tick();
    drive_op(rv.sgn, rv.a, rv.b);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      dif.start = 1'b0;
      dif.cpu_stall = (c >= 10 && c <= 14);
      @(negedge clk);
      if (c == 12) chk("cst.busy_frozen", 32'(dif.busy), 32'd1);
      if (dif.done) begin lat = c; break; end
    end
    chk("cst.lat", 32'(lat), 32'd38);
    chk("cst.quo", dif.quo, rv.q);
    chk("cst.rem", dif.rem, rv.r);
    dif.cpu_stall = 1'b1;
    tick();
    @(negedge clk);
    chk("cst.done_hold1", 32'(dif.done), 32'd1);
    tick();
    @(negedge clk);
    chk("cst.done_hold2", 32'(dif.done), 32'd1);
    tick();
    dif.cpu_stall = 1'b0;
    @(negedge clk);
    chk("cst.done_hold3", 32'(dif.done), 32'd1);
    tick();
    @(negedge clk);
    chk("cst.done_clear", 32'(dif.done), 32'd0);
    last_q = rv.q; last_r = rv.r; last_z = rv.z;

    // Back-to-back: new start in the DONE cycle, and a start pulse in CALC ignored.
    model(1'b1, 32'hFFFF_FF9C, 32'd7, rv.q, rv.r, rv.z);
    tick();
    drive_op(1'b0, 32'd1000, 32'd7);
    for (int c = 1; c <= 32; c++) begin
      tick();
      dif.start = 1'b0;
    end
    tick();
    drive_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    @(negedge clk);
    chk("b2b.done33", 32'(dif.done), 32'd1);
    chk("b2b.quo1", dif.quo, 32'd142);
    chk("b2b.rem1", dif.rem, 32'd6);
    chk("b2b.stall33", 32'(dif.stall), 32'd1);
    lat = -1;
    for (int c = 34; c <= 90; c++) begin
      tick();
      dif.start = 1'b0;
      if (c == 40) drive_op(1'b0, 32'd5, 32'd1);
      @(negedge clk);
      if (c == 34) chk("b2b.busy34", 32'(dif.busy), 32'd1);
      if (dif.done) begin lat = c; break; end
    end
    dif.start = 1'b0;
    chk("b2b.lat", 32'(lat), 32'd66);
    chk("b2b.quo2", dif.quo, rv.q);
    chk("b2b.rem2", dif.rem, rv.r);

    // Reset at CALC cycle 20 aborts with all outputs cleared.
    tick();
    drive_op(1'b0, 32'hDEAD_BEEF, 32'd13);
    for (int c = 1; c <= 20; c++) begin
      tick();
      dif.start = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    chk("rstc.stall20", 32'(dif.stall), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstc.busy", 32'(dif.busy), 32'd0);
    chk("rstc.quo", dif.quo, 32'd0);
    chk("rstc.rem", dif.rem, 32'd0);
    chk("rstc.dbz", 32'(dif.dbz), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.done) seen++;
    end
    chk("rstc.nodone", 32'(seen), 32'd0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rv.sgn = 1'($urandom_range(0, 1));
      rv.a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rv.b = 32'd0;
        1:       rv.b = $urandom_range(1, 16);
        2:       rv.b = 32'hFFFF_FFFF;
        default: rv.b = $urandom;
      endcase
      model(rv.sgn, rv.a, rv.b, rv.q, rv.r, rv.z);
      rv.lat = (rv.b == 32'd0) ? 1 : 33;
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
